// File: rtl/vga_map_arbiter.sv
// Time-shares the single-port tile-map RAM between game-logic accesses and a
// per-hblank burst that copies the next scan line's map row into a local buffer.
module vga_map_arbiter #(
    parameter int TILE_SHIFT = 5,
    parameter int MAP_W      = 20,
    parameter int MAP_H      = 15,
    parameter int AW         = 9,
    parameter int DW         = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [9:0]    i_pixel_x,
    input  logic [9:0]    i_pixel_y,
    input  logic          i_video_on,
    input  logic          i_g_req,
    input  logic          i_g_we,
    input  logic [AW-1:0] i_g_addr,
    input  logic [DW-1:0] i_g_wdata,
    output logic          o_g_ack,
    output logic [DW-1:0] o_g_rdata,
    output logic [AW-1:0] o_ram_addr,
    output logic          o_ram_we,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata,
    output logic [DW-1:0] o_tile_code,
    output logic          o_tile_valid,
    output logic          o_fetch_busy
);

    localparam int              CW       = $clog2(MAP_W);
    localparam logic [AW-1:0]   MAP_SIZE = AW'(MAP_W * MAP_H);
    localparam logic [AW-1:0]   MAP_W_V  = AW'(MAP_W);
    localparam logic [10:0]     Y_LIMIT  = 11'(MAP_H << TILE_SHIFT);
    localparam logic [CW-1:0]   COL_LAST = CW'(MAP_W - 1);

    typedef enum logic [2:0] {IDLE, GAME, GWAIT, FETCH, FLUSH} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_col;
    logic          r_video_d;
    logic          r_evt_pend;
    logic [AW-1:0] r_row_base;
    logic [DW-1:0] r_rowbuf [MAP_W];
    logic          r_g_rd;
    logic          r_g_oor;
    logic [DW-1:0] r_g_rdata;
    logic [DW-1:0] r_tile_code;
    logic          r_tile_valid;

    logic          w_fall;
    logic          w_busy;
    logic [10:0]   w_y_next;
    logic          w_wrap;
    logic [AW-1:0] w_target_row;
    logic [AW-1:0] w_row_base;
    logic          w_g_oor;
    logic [9:0]    w_tile_idx;
    logic          w_tile_in_range;
    logic [DW-1:0] w_rd_val;

    assign w_fall          = r_video_d & ~i_video_on;
    assign w_busy          = (r_state == FETCH) || (r_state == FLUSH);
    assign w_y_next        = {1'b0, i_pixel_y} + 11'd1;
    assign w_wrap          = (w_y_next >= Y_LIMIT);
    assign w_target_row    = w_wrap ? '0 : AW'(w_y_next >> TILE_SHIFT);
    assign w_g_oor         = (i_g_addr >= MAP_SIZE);
    assign w_tile_idx      = i_pixel_x >> TILE_SHIFT;
    assign w_tile_in_range = (w_tile_idx < 10'(MAP_W));
    assign w_rd_val        = r_g_oor ? '0 : i_ram_rdata;

    // Constant-coefficient multiply by MAP_W as a sum of shifted copies.
    always_comb begin
        w_row_base = '0;
        for (int b = 0; b < AW; b++) begin
            if (MAP_W_V[b]) begin
                w_row_base = w_row_base + (w_target_row << b);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        o_ram_addr  = '0;
        o_ram_we    = 1'b0;
        o_ram_wdata = '0;
        o_g_ack     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_evt_pend) begin
                    w_next = FETCH;
                end else if (i_g_req) begin
                    w_next = GAME;
                end
            end
            GAME: begin
                o_ram_addr  = i_g_addr;
                o_ram_we    = i_g_we & ~w_g_oor;
                o_ram_wdata = i_g_wdata;
                w_next      = GWAIT;
            end
            GWAIT: begin
                o_g_ack = 1'b1;
                w_next  = r_evt_pend ? FETCH : IDLE;
            end
            FETCH: begin
                o_ram_addr = r_row_base + AW'(r_col);
                if (r_col == COL_LAST) begin
                    w_next = FLUSH;
                end
            end
            FLUSH: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_col      <= '0;
            r_video_d  <= 1'b0;
            r_evt_pend <= 1'b0;
            r_row_base <= '0;
            r_g_rd     <= 1'b0;
            r_g_oor    <= 1'b0;
            r_g_rdata  <= '0;
        end else begin
            r_state   <= w_next;
            r_video_d <= i_video_on;
            // A refill event that lands while a burst already owns the RAM is dropped.
            if (w_fall && !w_busy) begin
                r_evt_pend <= 1'b1;
                r_row_base <= w_row_base;
            end else if (r_state == FETCH) begin
                r_evt_pend <= 1'b0;
            end
            r_col <= (r_state == FETCH && r_col != COL_LAST) ? r_col + CW'(1) : '0;
            if (r_state == GAME) begin
                r_g_rd  <= ~i_g_we;
                r_g_oor <= w_g_oor;
            end
            if (r_state == GWAIT && r_g_rd) begin
                r_g_rdata <= w_rd_val;
            end
        end
    end

    // RAM data lags the address by one cycle, so each column lands one cycle late.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < MAP_W; i++) begin
                r_rowbuf[i] <= '0;
            end
            r_tile_code  <= '0;
            r_tile_valid <= 1'b0;
        end else begin
            if (r_state == FETCH && r_col != '0) begin
                r_rowbuf[r_col - CW'(1)] <= i_ram_rdata;
            end
            if (r_state == FLUSH) begin
                r_rowbuf[MAP_W-1] <= i_ram_rdata;
            end
            r_tile_valid <= i_video_on;
            r_tile_code  <= (i_video_on && w_tile_in_range) ? r_rowbuf[w_tile_idx[CW-1:0]] : '0;
        end
    end

    assign o_g_rdata    = (r_state == GWAIT && r_g_rd) ? w_rd_val : r_g_rdata;
    assign o_fetch_busy = w_busy;
    assign o_tile_code  = r_tile_code;
    assign o_tile_valid = r_tile_valid;

endmodule

// File: tb/tb_vga_map_arbiter.sv
// Directed bench for vga_map_arbiter: drives a behavioural synchronous map RAM
// and walks through reset, game accesses, row refills, contention and range cases.
module tb_vga_map_arbiter;

    logic       clk = 1'b0;
    logic       rstN;
    logic [9:0] pixelX;
    logic [9:0] pixelY;
    logic       videoOn;
    logic       gReq;
    logic       gWe;
    logic [8:0] gAddr;
    logic [3:0] gWdata;
    logic       gAck;
    logic [3:0] gRdata;
    logic [8:0] ramAddr;
    logic       ramWe;
    logic [3:0] ramWdata;
    logic [3:0] ramRdata;
    logic [3:0] tileCode;
    logic       tileValid;
    logic       fetchBusy;

    logic       memLoad;
    logic [3:0] mem [512];

    int checkCount = 0;
    int passCount  = 0;

    always #10 clk = ~clk;

    vga_map_arbiter dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_pixel_x    (pixelX),
        .i_pixel_y    (pixelY),
        .i_video_on   (videoOn),
        .i_g_req      (gReq),
        .i_g_we       (gWe),
        .i_g_addr     (gAddr),
        .i_g_wdata    (gWdata),
        .o_g_ack      (gAck),
        .o_g_rdata    (gRdata),
        .o_ram_addr   (ramAddr),
        .o_ram_we     (ramWe),
        .o_ram_wdata  (ramWdata),
        .i_ram_rdata  (ramRdata),
        .o_tile_code  (tileCode),
        .o_tile_valid (tileValid),
        .o_fetch_busy (fetchBusy)
    );

    // Map contents: code = (col + row + 1) mod 16; unused addresses hold 4'hF.
    function automatic logic [3:0] initVal(input int a);
        if (a < 300) return 4'((a % 20) + (a / 20) + 1);
        return 4'hF;
    endfunction

    function automatic logic [3:0] tileExp(input int row, input int col);
        return 4'(col + row + 1);
    endfunction

    always @(posedge clk) begin
        if (memLoad) begin
            for (int a = 0; a < 512; a++) mem[a] <= initVal(a);
        end else if (ramWe) begin
            mem[ramAddr] <= ramWdata;
        end
        ramRdata <= mem[ramAddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vo, input logic [9:0] px, input logic [9:0] py,
                                 input logic req, input logic we, input logic [8:0] addr,
                                 input logic [3:0] wd);
        videoOn = vo;
        pixelX  = px;
        pixelY  = py;
        gReq    = req;
        gWe     = we;
        gAddr   = addr;
        gWdata  = wd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Drops video_on with the given scan line and follows the whole burst.
    task automatic doRefill(input logic [9:0] py, input int expBase);
        applyStimulus(1'b0, 10'd0, py, 1'b0, 1'b0, 9'd0, 4'd0);
        tick();
        checkOutput("evt_flag_not_busy", 16'(fetchBusy), 16'd0);
        checkOutput("blank_tile_valid", 16'(tileValid), 16'd0);
        checkOutput("blank_tile_code", 16'(tileCode), 16'd0);
        tick();
        for (int c = 0; c < 20; c++) begin
            checkOutput($sformatf("fetch_addr[%0d]", c), 16'(ramAddr), 16'(expBase + c));
            checkOutput($sformatf("fetch_busy[%0d]", c), 16'(fetchBusy), 16'd1);
            checkOutput($sformatf("fetch_we[%0d]", c), 16'(ramWe), 16'd0);
            tick();
        end
        checkOutput("flush_busy", 16'(fetchBusy), 16'd1);
        checkOutput("flush_addr", 16'(ramAddr), 16'd0);
        tick();
        checkOutput("after_burst_busy", 16'(fetchBusy), 16'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN    = 1'b0;
        memLoad = 1'b1;
        applyStimulus(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 9'd0, 4'd0);
        tick();
        tick();
        memLoad = 1'b0;
        checkOutput("rst_ack", 16'(gAck), 16'd0);
        checkOutput("rst_rdata", 16'(gRdata), 16'd0);
        checkOutput("rst_ram_addr", 16'(ramAddr), 16'd0);
        checkOutput("rst_ram_we", 16'(ramWe), 16'd0);
        checkOutput("rst_tile_code", 16'(tileCode), 16'd0);
        checkOutput("rst_tile_valid", 16'(tileValid), 16'd0);
        checkOutput("rst_busy", 16'(fetchBusy), 16'd0);
        rstN = 1'b1;
        tick();

        $display("[TB] game write then back-to-back read of address 45");
        applyStimulus(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 9'd45, 4'h7);
        checkOutput("wr_idle_we", 16'(ramWe), 16'd0);
        checkOutput("wr_idle_ack", 16'(gAck), 16'd0);
        tick();
        checkOutput("wr_game_addr", 16'(ramAddr), 16'd45);
        checkOutput("wr_game_we", 16'(ramWe), 16'd1);
        checkOutput("wr_game_wdata", 16'(ramWdata), 16'h7);
        checkOutput("wr_game_ack", 16'(gAck), 16'd0);
        tick();
        checkOutput("wr_gwait_ack", 16'(gAck), 16'd1);
        checkOutput("wr_gwait_we", 16'(ramWe), 16'd0);
        applyStimulus(1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 9'd45, 4'h0);
        tick();
        checkOutput("rd_idle_ack", 16'(gAck), 16'd0);
        checkOutput("rd_idle_we", 16'(ramWe), 16'd0);
        tick();
        checkOutput("rd_game_addr", 16'(ramAddr), 16'd45);
        checkOutput("rd_game_we", 16'(ramWe), 16'd0);
        tick();
        checkOutput("rd_gwait_ack", 16'(gAck), 16'd1);
        checkOutput("rd_gwait_rdata", 16'(gRdata), 16'h7);
        applyStimulus(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 9'd0, 4'h0);
        tick();
        checkOutput("rd_done_ack", 16'(gAck), 16'd0);
        checkOutput("rd_hold_rdata", 16'(gRdata), 16'h7);

        $display("[TB] row refill for scan line 95 (map row 3)");
        applyStimulus(1'b1, 10'd0, 10'd95, 1'b0, 1'b0, 9'd0, 4'd0);
        checkOutput("valid_lag", 16'(tileValid), 16'd0);
        tick();
        checkOutput("valid_follow", 16'(tileValid), 16'd1);
        checkOutput("empty_rowbuf", 16'(tileCode), 16'd0);
        tick();
        doRefill(10'd95, 60);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 10'(32 * k + ((k % 2 == 1) ? 31 : 0)), 10'd96,
                          1'b0, 1'b0, 9'd0, 4'd0);
            tick();
            checkOutput($sformatf("row3_tile[%0d]", k), 16'(tileCode), 16'(tileExp(3, k)));
        end
        applyStimulus(1'b1, 10'd640, 10'd96, 1'b0, 1'b0, 9'd0, 4'd0);
        tick();
        checkOutput("col20_tile", 16'(tileCode), 16'd0);
        applyStimulus(1'b1, 10'd1023, 10'd96, 1'b0, 1'b0, 9'd0, 4'd0);
        tick();
        checkOutput("col31_tile", 16'(tileCode), 16'd0);

        $display("[TB] last visible row and frame wrap");
        doRefill(10'd478, 280);
        applyStimulus(1'b1, 10'd0, 10'd479, 1'b0, 1'b0, 9'd0, 4'd0);
        tick();
        checkOutput("row14_tile0", 16'(tileCode), 16'(tileExp(14, 0)));
        tick();
        doRefill(10'd479, 0);
        applyStimulus(1'b1, 10'd32, 10'd0, 1'b0, 1'b0, 9'd0, 4'd0);
        checkOutput("wrap_valid_lag", 16'(tileValid), 16'd0);
        tick();
        checkOutput("wrap_valid", 16'(tileValid), 16'd1);
        checkOutput("row0_tile1", 16'(tileCode), 16'(tileExp(0, 1)));
        applyStimulus(1'b1, 10'd608, 10'd0, 1'b0, 1'b0, 9'd0, 4'd0);
        tick();
        checkOutput("row0_tile19", 16'(tileCode), 16'(tileExp(0, 19)));

        $display("[TB] reset in the middle of a burst");
        applyStimulus(1'b0, 10'd0, 10'd95, 1'b0, 1'b0, 9'd0, 4'd0);
        tick();
        tick();
        tick();
        tick();
        checkOutput("midburst_busy", 16'(fetchBusy), 16'd1);
        rstN = 1'b0;
        #1;
        checkOutput("abort_busy", 16'(fetchBusy), 16'd0);
        checkOutput("abort_ram_addr", 16'(ramAddr), 16'd0);
        checkOutput("abort_ack", 16'(gAck), 16'd0);
        checkOutput("abort_rdata", 16'(gRdata), 16'd0);
        checkOutput("abort_tile_code", 16'(tileCode), 16'd0);
        checkOutput("abort_tile_valid", 16'(tileValid), 16'd0);
        tick();
        rstN = 1'b1;
        applyStimulus(1'b1, 10'd64, 10'd95, 1'b0, 1'b0, 9'd0, 4'd0);
        checkOutput("post_rst_valid_lag", 16'(tileValid), 16'd0);
        tick();
        checkOutput("post_rst_valid", 16'(tileValid), 16'd1);
        checkOutput("post_rst_rowbuf", 16'(tileCode), 16'd0);

        $display("[TB] game request together with a pending refill");
        applyStimulus(1'b0, 10'd64, 10'd95, 1'b0, 1'b0, 9'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 10'd64, 10'd95, 1'b1, 1'b0, 9'd45, 4'd0);
        checkOutput("cont_idle_busy", 16'(fetchBusy), 16'd0);
        checkOutput("cont_idle_addr", 16'(ramAddr), 16'd0);
        tick();
        checkOutput("cont_fetch_first", 16'(fetchBusy), 16'd1);
        checkOutput("cont_fetch_addr", 16'(ramAddr), 16'd60);
        repeat (20) tick();
        checkOutput("cont_flush_busy", 16'(fetchBusy), 16'd1);
        checkOutput("cont_flush_ack", 16'(gAck), 16'd0);
        tick();
        checkOutput("cont_idle2_busy", 16'(fetchBusy), 16'd0);
        checkOutput("cont_idle2_ack", 16'(gAck), 16'd0);
        tick();
        checkOutput("cont_game_addr", 16'(ramAddr), 16'd45);
        checkOutput("cont_game_ack", 16'(gAck), 16'd0);
        tick();
        checkOutput("cont_ack", 16'(gAck), 16'd1);
        checkOutput("cont_rdata", 16'(gRdata), 16'h7);
        applyStimulus(1'b0, 10'd64, 10'd95, 1'b0, 1'b0, 9'd0, 4'd0);
        tick();
        checkOutput("cont_ack_done", 16'(gAck), 16'd0);

        $display("[TB] refill event arriving during a game access");
        applyStimulus(1'b1, 10'd0, 10'd127, 1'b0, 1'b0, 9'd0, 4'd0);
        tick();
        applyStimulus(1'b1, 10'd0, 10'd127, 1'b1, 1'b1, 9'd46, 4'h5);
        tick();
        checkOutput("evgame_addr", 16'(ramAddr), 16'd46);
        checkOutput("evgame_we", 16'(ramWe), 16'd1);
        applyStimulus(1'b0, 10'd0, 10'd127, 1'b1, 1'b1, 9'd46, 4'h5);
        tick();
        checkOutput("evgame_ack_first", 16'(gAck), 16'd1);
        checkOutput("evgame_not_busy", 16'(fetchBusy), 16'd0);
        applyStimulus(1'b0, 10'd0, 10'd127, 1'b0, 1'b0, 9'd0, 4'd0);
        tick();
        checkOutput("evgame_fetch", 16'(fetchBusy), 16'd1);
        checkOutput("evgame_fetch_addr", 16'(ramAddr), 16'd80);
        repeat (21) tick();
        checkOutput("evgame_done_busy", 16'(fetchBusy), 16'd0);
        applyStimulus(1'b1, 10'd64, 10'd128, 1'b0, 1'b0, 9'd0, 4'd0);
        tick();
        checkOutput("row4_tile2", 16'(tileCode), 16'(tileExp(4, 2)));

        $display("[TB] out-of-range write to 300 and read of 310");
        applyStimulus(1'b1, 10'd64, 10'd128, 1'b1, 1'b1, 9'd300, 4'hF);
        tick();
        checkOutput("oor_game_we", 16'(ramWe), 16'd0);
        tick();
        checkOutput("oor_wr_ack", 16'(gAck), 16'd1);
        applyStimulus(1'b1, 10'd64, 10'd128, 1'b1, 1'b0, 9'd310, 4'h0);
        tick();
        tick();
        checkOutput("oor_rd_game_we", 16'(ramWe), 16'd0);
        tick();
        checkOutput("oor_rd_ack", 16'(gAck), 16'd1);
        checkOutput("oor_rd_rdata", 16'(gRdata), 16'd0);
        applyStimulus(1'b1, 10'd64, 10'd128, 1'b0, 1'b0, 9'd0, 4'h0);
        tick();
        checkOutput("oor_rdata_hold", 16'(gRdata), 16'd0);
        checkOutput("oor_mem_untouched", 16'(mem[300]), 16'hF);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
